fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage RISC-V pipeline.
- Owns the program counter and drives the address of the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register, with stall, flush and branch/jump redirect support.
- Sits between the hazard/branch-resolution logic (EX stage) and the decode stage.

Parameters:
- ResetPC, 32'h0000_0000, PC value loaded on reset.
- BitSize, 8, log2 of instruction-memory word count. Valid PCs satisfy PC[31:BitSize+2] == 0.
- NopInstr, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Stall  in  1  hazard unit request to hold PC and IF/ID.
- Flush  in  1  hazard unit request to replace IF/ID content with a bubble.
- Redirect  in  1  taken branch or jump resolved in EX.
- RedirectTarget  in  32  target address for Redirect.
- ImemAddress  out  32  address to instruction memory; equals PC, combinational.
- ImemInstruction  in  32  word returned by instruction memory, same cycle.
- PC  out  32  current fetch PC.
- IF_ID_Instruction  out  32  registered instruction to decode.
- IF_ID_PC  out  32  PC of IF_ID_Instruction.
- IF_ID_PCPlus4  out  32  IF_ID_PC + 4.
- IF_ID_Valid  out  1  IF/ID holds a real instruction.
- FaultMisaligned  out  1  one-cycle pulse: last redirect target had [1:0] != 0.
- FaultRange  out  1  registered with IF/ID: the captured PC was outside instruction memory.
- FetchCount  out  32  number of valid instructions delivered to IF/ID.

Behaviour:
- Reset (Reset_n=0, asynchronous, any cycle including mid-stall or mid-redirect):
  - PC=ResetPC.
  - IF_ID_Instruction=NopInstr; IF_ID_PC=0; IF_ID_PCPlus4=0.
  - IF_ID_Valid=0; FaultMisaligned=0; FaultRange=0; FetchCount=0.
- ImemAddress = PC combinationally. Instruction memory returns the word combinationally.
- Latency: the word at PC reaches the IF_ID_* outputs one clock edge later.
- Next-PC priority, evaluated each rising edge:
  1. Redirect: PC <= {RedirectTarget[31:2],2'b00}. Redirect overrides Stall.
  2. Stall: PC holds.
  3. Otherwise: PC <= PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Misaligned redirect:
  - If Redirect=1 and RedirectTarget[1:0] != 0, FaultMisaligned=1 for exactly the following cycle, else 0.
  - The PC still loads the aligned target.
- IF/ID update priority, each rising edge:
  1. Redirect or Flush: load bubble (Instruction=NopInstr, PC=0, PCPlus4=0, Valid=0, FaultRange=0). This squashes the wrong-path word fetched in the redirect cycle.
  2. Stall: all IF_ID_* outputs and FaultRange hold.
  3. Otherwise: Instruction=ImemInstruction, IF_ID_PC=PC, PCPlus4=PC+4, Valid=1, and FaultRange as below.
- Out-of-range capture: if PC[31:BitSize+2] != 0 at capture, Instruction=NopInstr, Valid=0, FaultRange=1. The PC still advances normally.
- Simultaneous events:
  - Flush+Stall: IF/ID flushes, PC holds.
  - Redirect+Stall: PC redirects, IF/ID flushes.
  - Redirect+Flush: same as Redirect.
- FetchCount increments by 1 on each edge where IF_ID_Valid is loaded with 1. Wraps modulo 2^32. Holds during stall.
- No combinational path from Stall, Flush or Redirect to any IF_ID_* output. All IF_ID_* outputs are registered.

Test Plan:
- Reset release, ImemInstruction = 32'h00500093 for PC=0 -> edge 1: IF_ID_Instruction=32'h00500093, IF_ID_PC=0, IF_ID_PCPlus4=4, Valid=1, PC=4, FetchCount=1.
- Stall high for 2 cycles at PC=8 -> PC stays 8 and IF_ID outputs are frozen; after release PC=12 and FetchCount resumes counting.
- Redirect=1, RedirectTarget=32'h40 while PC=16 -> next edge: PC=32'h40, Valid=0, IF_ID_Instruction=32'h13; the following edge captures the word at 32'h40.
- Redirect, RedirectTarget=32'h42 -> PC=32'h40 and FaultMisaligned=1 for exactly one cycle; Redirect+Stall together also give PC=target and Valid=0.
- PC driven to 32'h400 with BitSize=8 -> FaultRange=1, Valid=0, Instruction=32'h13, FetchCount unchanged. Then redirect to 32'hFFFF_FFFC: the following edge gives PC=0 (wrap).
- Reset_n pulsed low asynchronously mid-stall at PC=32'h20 -> PC=0 and all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the combinational instruction
// memory and registers the returned word into IF/ID with stall/flush/redirect.
module fetch_stage #(
    parameter logic [31:0] ResetPC  = 32'h0000_0000,
    parameter int          BitSize  = 8,
    parameter logic [31:0] NopInstr = 32'h0000_0013
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        FaultMisaligned,
    output logic        FaultRange,
    output logic [31:0] FetchCount
);

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic pc_in_range(input logic [31:0] addr);
        return (addr >> (BitSize + 2)) == 32'd0;
    endfunction

    logic [31:0] pc_p0;
    logic [31:0] pc_plus4_p0;
    logic        in_range_p0;

    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] pc_plus4_p1;
    logic        vld_p1;
    logic        fault_mis_p1;
    logic        fault_rng_p1;
    logic [31:0] fetch_cnt_p1;

    // Stage 0: PC register and instruction-memory address
    assign pc_plus4_p0 = pc_p0 + 32'd4;
    assign in_range_p0 = pc_in_range(pc_p0);
    assign ImemAddress = pc_p0;
    assign PC          = pc_p0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_p0 <= ResetPC;
        end else if (Redirect) begin
            pc_p0 <= align_word(RedirectTarget);
        end else if (!Stall) begin
            pc_p0 <= pc_plus4_p0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fault_mis_p1 <= 1'b0;
        end else begin
            fault_mis_p1 <= Redirect && (RedirectTarget[1:0] != 2'b00);
        end
    end

    // Stage 1: IF/ID register; redirect also squashes the wrong-path word
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_p1     <= NopInstr;
            pc_p1        <= 32'd0;
            pc_plus4_p1  <= 32'd0;
            vld_p1       <= 1'b0;
            fault_rng_p1 <= 1'b0;
            fetch_cnt_p1 <= 32'd0;
        end else if (Redirect || Flush) begin
            instr_p1     <= NopInstr;
            pc_p1        <= 32'd0;
            pc_plus4_p1  <= 32'd0;
            vld_p1       <= 1'b0;
            fault_rng_p1 <= 1'b0;
        end else if (!Stall) begin
            instr_p1     <= in_range_p0 ? ImemInstruction : NopInstr;
            pc_p1        <= pc_p0;
            pc_plus4_p1  <= pc_plus4_p0;
            vld_p1       <= in_range_p0;
            fault_rng_p1 <= !in_range_p0;
            fetch_cnt_p1 <= fetch_cnt_p1 + {31'd0, in_range_p0};
        end
    end

    assign IF_ID_Instruction = instr_p1;
    assign IF_ID_PC          = pc_p1;
    assign IF_ID_PCPlus4     = pc_plus4_p1;
    assign IF_ID_Valid       = vld_p1;
    assign FaultMisaligned   = fault_mis_p1;
    assign FaultRange        = fault_rng_p1;
    assign FetchCount        = fetch_cnt_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, and
// randomized traffic checked against a behavioural fetch model.
module tb_fetch_stage;

    logic        Clk;
    logic        Reset_n;
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        FaultMisaligned;
    logic        FaultRange;
    logic [31:0] FetchCount;

    fetch_stage dut (
        .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush),
        .Redirect(Redirect), .RedirectTarget(RedirectTarget),
        .ImemAddress(ImemAddress), .ImemInstruction(ImemInstruction),
        .PC(PC), .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC(IF_ID_PC),
        .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid),
        .FaultMisaligned(FaultMisaligned), .FaultRange(FaultRange),
        .FetchCount(FetchCount)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned MEM_BYTES = 1024;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0] mem [256];
    assign ImemInstruction = mem[ImemAddress[9:2]];

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // Behavioural model: architectural fetch state
    logic [31:0] m_pc, m_ins, m_ipc, m_ip4, m_cnt;
    logic        m_vld, m_fm, m_fr;

    task automatic m_reset();
        m_pc = 0; m_ins = NOP; m_ipc = 0; m_ip4 = 0; m_cnt = 0;
        m_vld = 0; m_fm = 0; m_fr = 0;
    endtask

    task automatic m_step(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
        logic [31:0] npc;
        bit ok;
        if (rd)       npc = tgt - (tgt % 4);
        else if (st)  npc = m_pc;
        else          npc = m_pc + 4;
        m_fm = rd && (tgt % 4 != 0);
        if (rd || fl) begin
            m_ins = NOP; m_ipc = 0; m_ip4 = 0; m_vld = 0; m_fr = 0;
        end else if (!st) begin
            ok = m_pc < MEM_BYTES;
            m_ins = ok ? mem[(m_pc / 4) % 256] : NOP;
            m_ipc = m_pc; m_ip4 = m_pc + 4; m_vld = ok; m_fr = !ok;
            if (ok) m_cnt = m_cnt + 1;
        end
        m_pc = npc;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"}, PC, m_pc);
        chk({tag, ".addr"}, ImemAddress, m_pc);
        chk({tag, ".ins"}, IF_ID_Instruction, m_ins);
        chk({tag, ".ifpc"}, IF_ID_PC, m_ipc);
        chk({tag, ".ip4"}, IF_ID_PCPlus4, m_ip4);
        chk({tag, ".vld"}, {31'd0, IF_ID_Valid}, {31'd0, m_vld});
        chk({tag, ".fm"}, {31'd0, FaultMisaligned}, {31'd0, m_fm});
        chk({tag, ".fr"}, {31'd0, FaultRange}, {31'd0, m_fr});
        chk({tag, ".cnt"}, FetchCount, m_cnt);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"}, PC, 32'd0);
        chk({tag, ".ins"}, IF_ID_Instruction, NOP);
        chk({tag, ".ifpc"}, IF_ID_PC, 32'd0);
        chk({tag, ".ip4"}, IF_ID_PCPlus4, 32'd0);
        chk({tag, ".vld"}, {31'd0, IF_ID_Valid}, 32'd0);
        chk({tag, ".fm"}, {31'd0, FaultMisaligned}, 32'd0);
        chk({tag, ".fr"}, {31'd0, FaultRange}, 32'd0);
        chk({tag, ".cnt"}, FetchCount, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Stall = 0; Flush = 0; Redirect = 0; RedirectTarget = 0;
        Reset_n = 0;
        #2;
        chk_reset("reset");
        @(negedge Clk);
        Reset_n = 1;
        m_reset();
    endtask

    task automatic step(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
        Stall = st; Flush = fl; Redirect = rd; RedirectTarget = tgt;
        m_step(st, fl, rd, tgt);
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic        st, fl, rd;
        logic [31:0] tgt;
        logic [31:0] pc, ifpc, ip4, ins;
        logic        vld, fm, fr;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic fl, input logic rd, input logic [31:0] tgt,
                                input logic [31:0] pc, input logic [31:0] ifpc, input logic [31:0] ip4,
                                input logic [31:0] ins, input logic vld, input logic fm, input logic fr,
                                input logic [31:0] cnt);
        vec_t v;
        v.st = st; v.fl = fl; v.rd = rd; v.tgt = tgt; v.pc = pc; v.ifpc = ifpc; v.ip4 = ip4;
        v.ins = ins; v.vld = vld; v.fm = fm; v.fr = fr; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [31:0] fixw(input int i);
        return (i == 0) ? 32'h0050_0093 : (32'hA000_0000 | i);
    endfunction

    vec_t tbl[20];

    initial begin
        Reset_n = 0; Stall = 0; Flush = 0; Redirect = 0; RedirectTarget = 0;
        for (int i = 0; i < 256; i++) mem[i] = fixw(i);

        tbl[0]  = mk(0,0,0,0,            32'h4,   0,     32'h4,   fixw(0), 1,0,0,1);
        tbl[1]  = mk(0,0,0,0,            32'h8,   32'h4, 32'h8,   fixw(1), 1,0,0,2);
        tbl[2]  = mk(1,0,0,0,            32'h8,   32'h4, 32'h8,   fixw(1), 1,0,0,2);
        tbl[3]  = mk(1,0,0,0,            32'h8,   32'h4, 32'h8,   fixw(1), 1,0,0,2);
        tbl[4]  = mk(0,0,0,0,            32'hC,   32'h8, 32'hC,   fixw(2), 1,0,0,3);
        tbl[5]  = mk(0,0,0,0,            32'h10,  32'hC, 32'h10,  fixw(3), 1,0,0,4);
        tbl[6]  = mk(0,0,1,32'h40,       32'h40,  0,     0,       NOP,     0,0,0,4);
        tbl[7]  = mk(0,0,0,0,            32'h44,  32'h40,32'h44,  fixw(16),1,0,0,5);
        tbl[8]  = mk(0,0,1,32'h42,       32'h40,  0,     0,       NOP,     0,1,0,5);
        tbl[9]  = mk(0,0,0,0,            32'h44,  32'h40,32'h44,  fixw(16),1,0,0,6);
        tbl[10] = mk(1,0,1,32'h80,       32'h80,  0,     0,       NOP,     0,0,0,6);
        tbl[11] = mk(1,1,0,0,            32'h80,  0,     0,       NOP,     0,0,0,6);
        tbl[12] = mk(0,0,1,32'h400,      32'h400, 0,     0,       NOP,     0,0,0,6);
        tbl[13] = mk(0,0,0,0,            32'h404, 32'h400,32'h404,NOP,     0,0,1,6);
        tbl[14] = mk(1,0,0,0,            32'h404, 32'h400,32'h404,NOP,     0,0,1,6);
        tbl[15] = mk(0,0,1,32'hFFFF_FFFC,32'hFFFF_FFFC,0,0,       NOP,     0,0,0,6);
        tbl[16] = mk(0,0,0,0,            32'h0,   32'hFFFF_FFFC,0,NOP,     0,0,1,6);
        tbl[17] = mk(0,0,0,0,            32'h4,   0,     32'h4,   fixw(0), 1,0,0,7);
        tbl[18] = mk(0,1,0,0,            32'h8,   0,     0,       NOP,     0,0,0,7);
        tbl[19] = mk(0,0,0,0,            32'hC,   32'h8, 32'hC,   fixw(2), 1,0,0,8);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].st, tbl[i].fl, tbl[i].rd, tbl[i].tgt);
            chk($sformatf("v%0d.pc", i), PC, tbl[i].pc);
            chk($sformatf("v%0d.addr", i), ImemAddress, tbl[i].pc);
            chk($sformatf("v%0d.ifpc", i), IF_ID_PC, tbl[i].ifpc);
            chk($sformatf("v%0d.ip4", i), IF_ID_PCPlus4, tbl[i].ip4);
            chk($sformatf("v%0d.ins", i), IF_ID_Instruction, tbl[i].ins);
            chk($sformatf("v%0d.vld", i), {31'd0, IF_ID_Valid}, {31'd0, tbl[i].vld});
            chk($sformatf("v%0d.fm", i), {31'd0, FaultMisaligned}, {31'd0, tbl[i].fm});
            chk($sformatf("v%0d.fr", i), {31'd0, FaultRange}, {31'd0, tbl[i].fr});
            chk($sformatf("v%0d.cnt", i), FetchCount, tbl[i].cnt);
        end

        // Asynchronous reset in the middle of a stall at PC=0x20
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("async.pre_pc", PC, 32'h20);
        chk("async.pre_cnt", FetchCount, 32'd8);
        #3;
        Reset_n = 0;
        #1;
        chk_reset("async");
        @(negedge Clk);
        Stall = 0;
        Reset_n = 1;
        m_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int n = 0; n < 1500; n++) begin
            logic st, fl, rd;
            logic [31:0] tgt;
            st = ($urandom % 4) == 0;
            fl = ($urandom % 8) == 0;
            rd = ($urandom % 6) == 0;
            tgt = (($urandom % 5) == 0) ? $urandom : $urandom_range(0, 1100);
            if (($urandom % 40) == 0) tgt = 32'hFFFF_FFFC;
            step(st, fl, rd, tgt);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
